// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: queue entry layout and recovery FSM states.
// No logic of its own; the mispredict rule lives here so every user agrees on it.
// No flow control; pure type and function definitions.
package bru_pkg;

  // Index width baked into the entry layout; the top's IDX_W must equal this.
  localparam int BRU_IDX_W = 4;

  typedef struct packed {
    logic                 taken;
    logic [31:0]          addr;
    logic [31:0]          fallthru;
    logic [BRU_IDX_W-1:0] lhr_idx;
    logic [BRU_IDX_W-1:0] lhpt_idx;
    logic [BRU_IDX_W-1:0] btb_idx;
  } bru_entry_t;

  typedef enum logic {
    RUN,
    RECOVER
  } bru_state_e;

  // Wrong direction, or right direction (taken) but wrong target.
  function automatic logic is_mispredict(input bru_entry_t e, input logic taken,
                                         input logic [31:0] target);
    return (taken != e.taken) || (taken && (target != e.addr));
  endfunction

endpackage

// File: rtl/bru_pred_fifo.sv
// In-order prediction queue: head is the oldest outstanding branch, clear empties it.
// Latency: a push is visible at head one cycle later; no write-to-read bypass.
// Backpressure: push ignored when full (unless cleared), pop ignored when empty; clear wins.
module bru_pred_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter type entry_t = bru_entry_t
) (
  input  logic   clk,
  input  logic   Reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  input  logic   clear,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  entry_t           mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  // Entry storage; pointers alone define validity so no reset is needed here.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; reset and clear both empty the queue.
  always_ff @(posedge clk) begin
    if (Reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches fetch predictions against EX outcomes, drives predictor update and mispredict flush.
// Latency: resolve at edge N gives upd_*/flush/redirect_pc for exactly the cycle after edge N.
// Backpressure: pred_ready low when queue full or recovering; unaccepted pushes are dropped.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = BRU_IDX_W,
  parameter int CNT_W = 16,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [31:0]      pred_addr,
  input  logic [31:0]      pred_fallthru,
  input  logic [IDX_W-1:0] pred_lhr_idx,
  input  logic [IDX_W-1:0] pred_lhpt_idx,
  input  logic [IDX_W-1:0] pred_btb_idx,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic [31:0]      upd_target,
  output logic [IDX_W-1:0] upd_lhr_idx,
  output logic [IDX_W-1:0] upd_lhpt_idx,
  output logic [IDX_W-1:0] upd_btb_idx,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             err_underflow
);

  localparam int HOLD_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

  bru_state_e  state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;

  bru_entry_t  push_entry;
  bru_entry_t  head;
  logic        q_full;
  logic        q_empty;
  logic        pop;
  logic        mispred;
  logic        push;
  logic [31:0] correct_pc;

  assign pred_ready = !q_full && (state == RUN);
  assign pop        = res_valid && !q_empty;
  assign mispred    = pop && is_mispredict(head, res_taken, res_target);
  assign correct_pc = res_taken ? res_target : head.fallthru;
  // A push in the same cycle as a mispredict is wrong-path and must not survive the clear.
  assign push       = pred_valid && pred_ready && !mispred;

  assign push_entry = '{taken:    pred_taken,
                        addr:     pred_addr,
                        fallthru: pred_fallthru,
                        lhr_idx:  pred_lhr_idx,
                        lhpt_idx: pred_lhpt_idx,
                        btb_idx:  pred_btb_idx};

  bru_pred_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (bru_entry_t)
  ) u_fifo (
    .clk       (clk),
    .Reset     (Reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (mispred),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Recovery FSM state register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= RUN;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Next state: a mispredict blocks fetch pushes for HOLD cycles to drain the wrong path.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      RUN: begin
        if (mispred && (HOLD > 0)) begin
          state_nxt    = RECOVER;
          hold_cnt_nxt = HOLD_W'(HOLD);
        end
      end
      RECOVER: begin
        if (hold_cnt <= HOLD_W'(1)) begin
          state_nxt    = RUN;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt    = RUN;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // Update/flush outputs are single-cycle pulses; payloads are zero when not strobed.
  always_ff @(posedge clk) begin
    if (Reset) begin
      upd_valid    <= 1'b0;
      upd_taken    <= 1'b0;
      upd_target   <= '0;
      upd_lhr_idx  <= '0;
      upd_lhpt_idx <= '0;
      upd_btb_idx  <= '0;
      flush        <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      upd_valid    <= pop;
      upd_taken    <= pop && res_taken;
      upd_target   <= pop ? correct_pc : '0;
      upd_lhr_idx  <= pop ? head.lhr_idx  : '0;
      upd_lhpt_idx <= pop ? head.lhpt_idx : '0;
      upd_btb_idx  <= pop ? head.btb_idx  : '0;
      flush        <= mispred;
      redirect_pc  <= mispred ? correct_pc : '0;
    end
  end

  // Saturating statistics and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (Reset) begin
      branch_cnt    <= '0;
      mispred_cnt   <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (pop && (branch_cnt != '1))      branch_cnt  <= branch_cnt + 1'b1;
      if (mispred && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 1'b1;
      if (res_valid && q_empty)           err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int DEPTH = 8;
  localparam int HOLD  = 1;

  logic        clk = 1'b0;
  logic        Reset;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_addr, pred_fallthru;
  logic [3:0]  pred_lhr_idx, pred_lhpt_idx, pred_btb_idx;
  logic        pred_ready;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        upd_valid, upd_taken;
  logic [31:0] upd_target;
  logic [3:0]  upd_lhr_idx, upd_lhpt_idx, upd_btb_idx;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt, mispred_cnt;
  logic        err_underflow;

  branch_resolve_unit #(.DEPTH(DEPTH), .IDX_W(4), .CNT_W(16), .HOLD(HOLD)) dut (
    .clk(clk), .Reset(Reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_addr(pred_addr),
    .pred_fallthru(pred_fallthru), .pred_lhr_idx(pred_lhr_idx),
    .pred_lhpt_idx(pred_lhpt_idx), .pred_btb_idx(pred_btb_idx), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_lhr_idx(upd_lhr_idx), .upd_lhpt_idx(upd_lhpt_idx), .upd_btb_idx(upd_btb_idx),
    .flush(flush), .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: outstanding predictions as a plain queue.
  typedef struct {
    logic        taken;
    logic [31:0] addr;
    logic [31:0] fallthru;
    logic [3:0]  i_lhr, i_lhpt, i_btb;
  } pred_t;

  typedef struct {
    int          due;
    logic        taken;
    logic [31:0] target;
    logic [3:0]  i_lhr, i_lhpt, i_btb;
    logic        flush;
    logic [31:0] redir;
    int          bcnt, mcnt;
  } exp_t;

  pred_t mq[$];
  exp_t  expq[$];
  int    rec_left = 0;
  int    m_bcnt = 0;
  int    m_mcnt = 0;
  logic  m_err = 1'b0;
  logic  mon_en = 1'b0;

  // One clock: apply inputs, advance the model across the coming edge, record expectations.
  task automatic step(input logic pv, input logic pt, input logic [31:0] pa,
                      input logic [31:0] pf, input logic [3:0] i0, input logic [3:0] i1,
                      input logic [3:0] i2, input logic rv, input logic rt,
                      input logic [31:0] rtg);
    logic  ready, mis;
    pred_t h, n;
    exp_t  e;
    pred_valid = pv; pred_taken = pt; pred_addr = pa; pred_fallthru = pf;
    pred_lhr_idx = i0; pred_lhpt_idx = i1; pred_btb_idx = i2;
    res_valid = rv; res_taken = rt; res_target = rtg;
    ready = (mq.size() < DEPTH) && (rec_left == 0);
    chk("pred_ready", {63'd0, pred_ready}, {63'd0, ready});
    mis = 1'b0;
    if (rv && mq.size() == 0) m_err = 1'b1;
    if (rv && mq.size() > 0) begin
      h = mq[0];
      mis = (rt != h.taken) || (rt && rtg != h.addr);
      m_bcnt = (m_bcnt == 65535) ? m_bcnt : m_bcnt + 1;
      if (mis) m_mcnt = (m_mcnt == 65535) ? m_mcnt : m_mcnt + 1;
      e.due = cyc + 1; e.taken = rt; e.target = rt ? rtg : h.fallthru;
      e.i_lhr = h.i_lhr; e.i_lhpt = h.i_lhpt; e.i_btb = h.i_btb;
      e.flush = mis; e.redir = rt ? rtg : h.fallthru;
      e.bcnt = m_bcnt; e.mcnt = m_mcnt;
      expq.push_back(e);
    end
    if (mis) begin
      mq.delete();
      rec_left = HOLD;
    end else begin
      if (rec_left > 0) rec_left--;
      if (rv && mq.size() > 0) void'(mq.pop_front());
      if (pv && ready) begin
        n.taken = pt; n.addr = pa; n.fallthru = pf; n.i_lhr = i0; n.i_lhpt = i1; n.i_btb = i2;
        mq.push_back(n);
      end
    end
    @(posedge clk); #1;
    chk("err_underflow", {63'd0, err_underflow}, {63'd0, m_err});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_pred(input logic pt, input logic [31:0] pa, input logic [31:0] pf);
    step(1, pt, pa, pf, 4'($urandom), 4'($urandom), 4'($urandom), 0, 0, 0);
  endtask

  task automatic resolve_match();
    if (mq.size() > 0) step(0, 0, 0, 0, 0, 0, 0, 1, mq[0].taken, mq[0].addr);
    else idle();
  endtask

  task automatic do_reset(input logic rv, input logic pv);
    pred_valid = pv; pred_taken = 1; pred_addr = 32'h300; pred_fallthru = 32'h8;
    res_valid = rv; res_taken = 1; res_target = 32'h999;
    Reset = 1'b1;
    mq.delete(); rec_left = 0; m_bcnt = 0; m_mcnt = 0; m_err = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b0;
    pred_valid = 0; res_valid = 0;
    chk("rst_upd_valid", {63'd0, upd_valid}, 64'd0);
    chk("rst_upd_target", {32'd0, upd_target}, 64'd0);
    chk("rst_flush", {63'd0, flush}, 64'd0);
    chk("rst_redirect", {32'd0, redirect_pc}, 64'd0);
    chk("rst_branch_cnt", {48'd0, branch_cnt}, 64'd0);
    chk("rst_mispred_cnt", {48'd0, mispred_cnt}, 64'd0);
    chk("rst_err", {63'd0, err_underflow}, 64'd0);
    chk("rst_pred_ready", {63'd0, pred_ready}, 64'd1);
  endtask

  // Monitor: consume one expectation per update pulse; flag spurious or missing pulses.
  exp_t me;
  always @(negedge clk) begin
    if (mon_en) begin
      if (upd_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_upd_valid", 64'd1, 64'd0);
        end else begin
          me = expq.pop_front();
          chk("upd_latency", 64'(cyc), 64'(me.due));
          chk("upd_taken", {63'd0, upd_taken}, {63'd0, me.taken});
          chk("upd_target", {32'd0, upd_target}, {32'd0, me.target});
          chk("upd_idx", {52'd0, upd_lhr_idx, upd_lhpt_idx, upd_btb_idx},
              {52'd0, me.i_lhr, me.i_lhpt, me.i_btb});
          chk("flush", {63'd0, flush}, {63'd0, me.flush});
          if (me.flush) chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, me.redir});
          chk("branch_cnt", {48'd0, branch_cnt}, 64'(me.bcnt));
          chk("mispred_cnt", {48'd0, mispred_cnt}, 64'(me.mcnt));
        end
      end else if (flush) begin
        chk("spurious_flush", 64'd1, 64'd0);
      end
      if (expq.size() > 0 && expq[0].due < cyc) begin
        chk("missing_upd_valid", 64'd0, 64'd1);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] tg[3];
    tg[0] = 32'h100; tg[1] = 32'h200; tg[2] = 32'h300;
    Reset = 1'b1;
    pred_valid = 0; pred_taken = 0; pred_addr = 0; pred_fallthru = 0;
    pred_lhr_idx = 0; pred_lhpt_idx = 0; pred_btb_idx = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset(0, 0);

    // Correct taken prediction.
    step(1, 1, 32'h100, 32'h4, 4'h1, 4'h2, 4'h3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h100);
    idle();
    // Not-taken predicted, actually taken: flush to 0x80, then a recovery cycle.
    step(1, 0, 32'h200, 32'h44, 4'h5, 4'h6, 4'h7, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h80);
    idle();
    idle();

    // Fill the queue, attempt one extra push, then resolve all in order.
    for (int i = 0; i < DEPTH + 1; i++) push_pred(i[0], 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 4));
    for (int i = 0; i < DEPTH; i++) resolve_match();
    idle();

    // Mispredict with younger entries and a same-cycle push, then recovery and re-entry.
    for (int i = 0; i < 4; i++) push_pred(1, 32'h400, 32'h500);
    step(1, 1, 32'h600, 32'h604, 4'h9, 4'h9, 4'h9, 1, 0, 0);
    push_pred(1, 32'h700, 32'h704);
    push_pred(0, 32'h800, 32'h804);
    resolve_match();
    idle();

    // Underflow: resolve on empty queue, flag stays set.
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h100);
    repeat (3) idle();

    // Reset with entries queued and a concurrent resolve/push.
    for (int i = 0; i < 4; i++) push_pred(1, 32'h100, 32'h104);
    do_reset(1, 1);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      logic pv, rv, rt;
      logic [31:0] rtg;
      pv  = ($urandom_range(0, 99) < 60);
      rv  = ($urandom_range(0, 99) < 50);
      rt  = 1'($urandom);
      rtg = tg[$urandom_range(0, 2)];
      if (mq.size() > 0 && $urandom_range(0, 99) < 75) begin
        rt = mq[0].taken; rtg = mq[0].addr;
      end
      step(pv, 1'($urandom), tg[$urandom_range(0, 2)], $urandom & 32'hFFFF_FFFC,
           4'($urandom), 4'($urandom), 4'($urandom), rv, rt, rtg);
    end

    repeat (3) idle();
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-side counterpart of the local branch predictor. Records every prediction issued at fetch in an in-order queue, matches each against the actual outcome resolved in EX, and drives the predictor's update port (LHPT/LHR/BTB indices, taken, target). On a misprediction it raises a one-cycle flush with the corrected PC and discards all younger in-flight predictions.

## Interface
- DEPTH, 8: prediction queue entries (power of 2, ≥2)
- IDX_W, 4: width of LHR/LHPT/BTB indices
- CNT_W, 16: statistics counter width
- HOLD, 1: cycles pushes are ignored after a flush (wrong-path fetch drain, ≥0)

- clk  in  1  single clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- pred_valid  in  1  fetch issued a branch prediction this cycle
- pred_taken  in  1  predicted direction
- pred_addr  in  32  predicted next PC
- pred_fallthru  in  32  PC+4 of the branch
- pred_lhr_idx, pred_lhpt_idx, pred_btb_idx  in  IDX_W each  predictor indices captured at fetch
- pred_ready  out  1  combinational, = queue not full and not in RECOVER
- res_valid  in  1  EX resolved the oldest outstanding branch
- res_taken  in  1  actual direction
- res_target  in  32  actual taken target
- upd_valid  out  1  registered one-cycle pulse, predictor update strobe
- upd_taken  out  1  actual direction for update
- upd_target  out  32  res_target if taken, else pred_fallthru of entry
- upd_lhr_idx, upd_lhpt_idx, upd_btb_idx  out  IDX_W each  indices of resolved entry
- flush  out  1  registered one-cycle pulse on misprediction
- redirect_pc  out  32  correct PC, valid while flush=1
- branch_cnt, mispred_cnt  out  CNT_W each  resolved / mispredicted totals, saturating
- err_underflow  out  1  sticky; res_valid seen with empty queue

## Operation
- Entry = {taken, addr, fallthru, lhr_idx, lhpt_idx, btb_idx}; FIFO order, head = oldest.
- Push: pred_valid && pred_ready → write tail. Push with pred_ready=0 is dropped silently (fetch must stall).
- Pop: res_valid && !empty → read head. mispredict = (res_taken != head.taken) || (res_taken && res_target != head.addr).
- Correct PC = res_taken ? res_target : head.fallthru.
- Pop without mispredict: head advances; simultaneous push allowed, count unchanged (push while full still dropped since pred_ready=0).
- Pop with mispredict: entire queue cleared (head=tail, count=0) at that edge; same-cycle push discarded.
- res_valid with empty queue: no update, no flush, err_underflow set until Reset.
- Counters: branch_cnt +1 per pop, mispred_cnt +1 per mispredict; both hold at all-ones.
- FSM: RUN (normal) → RECOVER on mispredict when HOLD>0; RECOVER counts HOLD cycles with pred_ready=0, then RUN. HOLD=0: stay in RUN. res_valid in RECOVER with empty queue → underflow rule.
- Reset mid-operation: queue emptied, FSM RUN, counters/err cleared; wins over any concurrent push/pop.

## Timing
- Reset values: all outputs 0 except pred_ready=1.
- res_valid at edge N → upd_*, flush, redirect_pc valid for cycle after edge N, exactly one cycle; upd_valid asserted for every pop, correct or not.
- Push at edge N → entry poppable at edge N+1 (no same-edge bypass into empty queue).
- pred_ready low for cycles N+1..N+HOLD after mispredict at edge N.
- Back-to-back pops every cycle sustained.

## Structure
- Package bru_pkg: entry struct typedef, FSM state enum {RUN, RECOVER}.
- Sub-module bru_pred_fifo (DEPTH, entry type, push/pop/clear, full/empty, count); FSM, compare, counters and output registers in top.

## Test plan
- Push taken pred addr=0x100, resolve taken target=0x100 → upd_valid=1, upd_target=0x100, flush=0, branch_cnt=1.
- Push not-taken fallthru=0x44, resolve taken target=0x80 → flush=1, redirect_pc=0x80, mispred_cnt=1, queue empty.
- Fill 8 entries → pred_ready=0; 9th push dropped; 8 resolves match in order, indices echoed exactly.
- Mispredict with 3 younger entries and same-cycle push, HOLD=1 → queue empty, pred_ready=0 one cycle, next push accepted.
- res_valid on empty queue → no upd_valid/flush, err_underflow=1 sticky until Reset.
- Reset asserted with 4 entries queued and res_valid=1 → all outputs reset values next cycle, no update pulse.
